imm_decode_stage: RTL and testbench
===================================

IMM_DECODE_STAGE -- requirements
Module: imm_decode_stage

Interface
REQ-001 Parameter N, default 32: datapath width; SHALL be >= 32.
REQ-002 Parameter AUTO_FMT, default 1: 1 = format from opcode; 0 = format from fmt_sel.
REQ-003 Parameter CNT_W, default 16: illegal-counter width.
REQ-004 clk  input  1  sole clock; all state updates on rising edge.
REQ-005 rst  input  1  synchronous, active-high reset.
REQ-006 flush  input  1  discard all held entries.
REQ-007 in_valid  input  1  / in_ready  output  1  upstream handshake.
REQ-008 instr  input  32  instruction word.
REQ-009 fmt_sel  input  3  format select; used only when AUTO_FMT=0.
REQ-010 out_valid  output  1  / out_ready  input  1  downstream handshake.
REQ-011 imm  output  N  extended immediate.
REQ-012 fmt  output  3  resolved format code.
REQ-013 instr_out  output  32  instruction paired with imm.
REQ-014 illegal  output  1  format unresolvable.
REQ-015 illegal_cnt  output  CNT_W  count of illegal entries delivered.

Function
REQ-016 Format codes SHALL be: 0 I, 1 S, 2 B, 3 U, 4 J, 5 Z (CSR zimm), 6 NONE, 7 ILLEGAL.
REQ-017 Immediate bit fields SHALL follow RV32I for I/S/B/U/J; B and J bit 0 = 0; U low 12 bits = 0.
REQ-018 I/S/B/U/J SHALL sign-extend from instr[31] to N bits; Z SHALL zero-extend instr[19:15]; NONE and ILLEGAL SHALL give imm = 0.
REQ-019 AUTO_FMT=1 opcode map: 0010011/0000011/1100111 -> I; 0100011 -> S; 1100011 -> B; 0110111/0010111 -> U; 1101111 -> J; 1110011 -> Z if instr[14]=1, else I; 0110011 -> NONE; any other opcode -> ILLEGAL.
REQ-020 AUTO_FMT=0: fmt = fmt_sel; fmt_sel=7 -> ILLEGAL.
REQ-021 illegal SHALL be 1 exactly when fmt = 7.
REQ-022 Transfer occurs when valid and ready are both 1 on the same edge.
REQ-023 Latency SHALL be 1 cycle: an accepted instr appears on out_valid/imm/fmt/instr_out on the next cycle.
REQ-024 Throughput SHALL be 1 per cycle while out_ready = 1.
REQ-025 Storage SHALL be a 2-entry skid buffer: main (output) register plus skid register.
REQ-026 in_ready SHALL be 1 exactly when the skid register is empty; in_ready SHALL be driven from a register, never combinationally from out_ready.
REQ-027 Accept while main is full and out_ready = 0: the entry SHALL go to skid; in_ready SHALL drop next cycle.
REQ-028 Main dequeued while skid is full: skid SHALL move to main; simultaneous input is blocked by in_ready = 0.
REQ-029 Output order SHALL equal acceptance order; held outputs SHALL be stable while out_valid = 1 and out_ready = 0.
REQ-030 flush = 1 SHALL clear both entries next cycle (out_valid = 0, in_ready = 1).
REQ-031 An input accepted in the flush cycle SHALL be discarded.
REQ-032 flush SHALL not change illegal_cnt.
REQ-033 illegal_cnt SHALL increment on each output transfer with illegal = 1.
REQ-034 illegal_cnt SHALL saturate at 2^CNT_W-1.

Reset
REQ-035 rst SHALL set out_valid = 0, in_ready = 1, imm = 0, fmt = 0, instr_out = 0, illegal = 0, illegal_cnt = 0.
REQ-036 rst SHALL take priority over flush and over any handshake, including mid-stall.

Structure
REQ-037 Package imm_pkg SHALL hold the format-code constants and RV32I opcode constants.
REQ-038 Combinational format resolution and extension SHALL live in one sub-module, imm_extract, instantiated once at the input; the skid buffer SHALL store resolved results.

Verification
REQ-039 N=32, instr 0xFFF00093 (addi x1,x0,-1) -> next cycle imm 0xFFFFFFFF, fmt 0, illegal 0.
REQ-040 Directed format checks:
- 0xFE112E23 (sw) -> imm 0xFFFFFFFC, fmt 1.
- 0xFFDFF06F (jal) -> imm 0xFFFFFFFC, fmt 4.
- N=64, 0x800000B7 (lui) -> imm 0xFFFFFFFF80000000, fmt 3.
REQ-041 Backpressure: out_ready = 0 and three back-to-back instrs offered -> two accepted, in_ready = 0 from the cycle after the second accept; out_ready = 1 -> all three delivered in order, unchanged.
REQ-042 Flush during a full stall -> next cycle out_valid = 0 and in_ready = 1; no flushed entry is ever delivered.
REQ-043 Illegal counting, CNT_W=2: five deliveries of 0x0000007F -> illegal = 1 and fmt 7 each; illegal_cnt = 1, 2, 3, 3, 3.
REQ-044 rst asserted mid-stall -> all outputs reach REQ-035 values next cycle.

Source files
------------

// File: rtl/imm_pkg.sv
//------------------------------------------------------------------------------
// Module      : imm_pkg
// Description : Format codes, RV32I opcode constants and opcode-to-format map
//               shared by the immediate decode stage.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

package imm_pkg;

    typedef enum logic [2:0] {
        FMT_I       = 3'd0,
        FMT_S       = 3'd1,
        FMT_B       = 3'd2,
        FMT_U       = 3'd3,
        FMT_J       = 3'd4,
        FMT_Z       = 3'd5,
        FMT_NONE    = 3'd6,
        FMT_ILLEGAL = 3'd7
    } imm_fmt_e;

    localparam logic [6:0] c_OP_IMM    = 7'b0010011;
    localparam logic [6:0] c_OP_LOAD   = 7'b0000011;
    localparam logic [6:0] c_OP_JALR   = 7'b1100111;
    localparam logic [6:0] c_OP_STORE  = 7'b0100011;
    localparam logic [6:0] c_OP_BRANCH = 7'b1100011;
    localparam logic [6:0] c_OP_LUI    = 7'b0110111;
    localparam logic [6:0] c_OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] c_OP_JAL    = 7'b1101111;
    localparam logic [6:0] c_OP_SYSTEM = 7'b1110011;
    localparam logic [6:0] c_OP_REG    = 7'b0110011;

    // SYSTEM splits on funct3[2]: immediate-operand CSR ops carry a zimm.
    function automatic imm_fmt_e resolve_fmt(input logic [31:0] instr);
        case (instr[6:0])
            c_OP_IMM, c_OP_LOAD, c_OP_JALR: resolve_fmt = FMT_I;
            c_OP_STORE:                     resolve_fmt = FMT_S;
            c_OP_BRANCH:                    resolve_fmt = FMT_B;
            c_OP_LUI, c_OP_AUIPC:           resolve_fmt = FMT_U;
            c_OP_JAL:                       resolve_fmt = FMT_J;
            c_OP_SYSTEM:                    resolve_fmt = instr[14] ? FMT_Z : FMT_I;
            c_OP_REG:                       resolve_fmt = FMT_NONE;
            default:                        resolve_fmt = FMT_ILLEGAL;
        endcase
    endfunction

endpackage

`default_nettype wire

// File: rtl/imm_decode_stage_if.sv
//------------------------------------------------------------------------------
// Module      : imm_decode_stage_if
// Description : Upstream/downstream handshake bundle of the immediate decode stage.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

interface imm_decode_stage_if #(
    parameter int N     = 32,
    parameter int CNT_W = 16
);
    logic             flush;
    logic             in_valid;
    logic             in_ready;
    logic [31:0]      instr;
    logic [2:0]       fmt_sel;
    logic             out_valid;
    logic             out_ready;
    logic [N-1:0]     imm;
    logic [2:0]       fmt;
    logic [31:0]      instr_out;
    logic             illegal;
    logic [CNT_W-1:0] illegal_cnt;

    modport master (
        output flush, in_valid, instr, fmt_sel, out_ready,
        input  in_ready, out_valid, imm, fmt, instr_out, illegal, illegal_cnt
    );

    modport slave (
        input  flush, in_valid, instr, fmt_sel, out_ready,
        output in_ready, out_valid, imm, fmt, instr_out, illegal, illegal_cnt
    );
endinterface

`default_nettype wire

// File: rtl/imm_extract.sv
//------------------------------------------------------------------------------
// Module      : imm_extract
// Description : Combinational format resolution and immediate extension.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module imm_extract
    import imm_pkg::*;
#(
    parameter int N        = 32,
    parameter int AUTO_FMT = 1
) (
    input  logic [31:0]  instr,
    input  logic [2:0]   fmt_sel,
    output logic [N-1:0] imm,
    output logic [2:0]   fmt
);

    imm_fmt_e    w_fmt;
    logic        w_sign;
    logic [31:0] w_imm32;

    // Every 32-bit form already carries its final sign in bit 31, so one
    // signed widening covers both sign- and zero-extension.
    always_comb begin
        w_fmt   = (AUTO_FMT != 0) ? resolve_fmt(instr) : imm_fmt_e'(fmt_sel);
        w_sign  = instr[31];
        w_imm32 = '0;
        case (w_fmt)
            FMT_I:   w_imm32 = {{20{w_sign}}, instr[31:20]};
            FMT_S:   w_imm32 = {{20{w_sign}}, instr[31:25], instr[11:7]};
            FMT_B:   w_imm32 = {{19{w_sign}}, instr[31], instr[7], instr[30:25],
                                instr[11:8], 1'b0};
            FMT_U:   w_imm32 = {instr[31:12], 12'b0};
            FMT_J:   w_imm32 = {{11{w_sign}}, instr[31], instr[19:12], instr[20],
                                instr[30:21], 1'b0};
            FMT_Z:   w_imm32 = {27'b0, instr[19:15]};
            default: w_imm32 = '0;
        endcase
    end

    assign imm = N'($signed(w_imm32));
    assign fmt = w_fmt;

endmodule

`default_nettype wire

// File: rtl/imm_decode_stage.sv
//------------------------------------------------------------------------------
// Module      : imm_decode_stage
// Description : One-cycle immediate decode stage with a 2-entry skid buffer.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module imm_decode_stage
    import imm_pkg::*;
#(
    parameter int N        = 32,
    parameter int AUTO_FMT = 1,
    parameter int CNT_W    = 16
) (
    input  logic               clk,
    input  logic               rst,
    imm_decode_stage_if.slave  bus
);

    logic [N-1:0]     w_x_imm;
    logic [2:0]       w_x_fmt;
    logic             w_accept;
    logic             w_main_free;
    logic             w_deliver;

    logic             r_main_valid;
    logic [N-1:0]     r_main_imm;
    logic [2:0]       r_main_fmt;
    logic [31:0]      r_main_instr;
    logic             r_skid_valid;
    logic [N-1:0]     r_skid_imm;
    logic [2:0]       r_skid_fmt;
    logic [31:0]      r_skid_instr;
    logic [CNT_W-1:0] r_illegal_cnt;

    imm_extract #(
        .N        (N),
        .AUTO_FMT (AUTO_FMT)
    ) u_imm_extract (
        .instr   (bus.instr),
        .fmt_sel (bus.fmt_sel),
        .imm     (w_x_imm),
        .fmt     (w_x_fmt)
    );

    // Ready depends only on skid occupancy, keeping out_ready off the upstream path.
    assign bus.in_ready = ~r_skid_valid;
    assign w_accept     = bus.in_valid & ~r_skid_valid;
    assign w_main_free  = ~r_main_valid | bus.out_ready;
    assign w_deliver    = r_main_valid & bus.out_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_main_valid <= 1'b0;
            r_main_imm   <= '0;
            r_main_fmt   <= 3'd0;
            r_main_instr <= '0;
            r_skid_valid <= 1'b0;
            r_skid_imm   <= '0;
            r_skid_fmt   <= 3'd0;
            r_skid_instr <= '0;
        end else if (bus.flush) begin
            r_main_valid <= 1'b0;
            r_skid_valid <= 1'b0;
        end else if (w_main_free) begin
            if (r_skid_valid) begin
                r_main_valid <= 1'b1;
                r_main_imm   <= r_skid_imm;
                r_main_fmt   <= r_skid_fmt;
                r_main_instr <= r_skid_instr;
                r_skid_valid <= 1'b0;
            end else begin
                r_main_valid <= w_accept;
                if (w_accept) begin
                    r_main_imm   <= w_x_imm;
                    r_main_fmt   <= w_x_fmt;
                    r_main_instr <= bus.instr;
                end
            end
        end else if (w_accept) begin
            r_skid_valid <= 1'b1;
            r_skid_imm   <= w_x_imm;
            r_skid_fmt   <= w_x_fmt;
            r_skid_instr <= bus.instr;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_illegal_cnt <= '0;
        end else if (w_deliver && bus.illegal && (r_illegal_cnt != {CNT_W{1'b1}})) begin
            r_illegal_cnt <= r_illegal_cnt + CNT_W'(1);
        end
    end

    assign bus.out_valid   = r_main_valid;
    assign bus.imm         = r_main_imm;
    assign bus.fmt         = r_main_fmt;
    assign bus.instr_out   = r_main_instr;
    assign bus.illegal     = (r_main_fmt == FMT_ILLEGAL);
    assign bus.illegal_cnt = r_illegal_cnt;

endmodule

`default_nettype wire

// File: tb/tb_imm_decode_stage.sv
//------------------------------------------------------------------------------
// Module      : tb_imm_decode_stage
// Description : Scoreboard bench: 32-bit auto-format stage and 64-bit fmt_sel stage.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_imm_decode_stage;

    typedef struct {
        logic [31:0] instr;
        logic [63:0] imm;
        logic [2:0]  fmt;
        logic        ill;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    bit   mon_en = 1'b0;
    bit   b_done = 1'b0;
    int   total = 0;
    int   bad = 0;
    int   cnt_a = 0;
    int   cnt_b = 0;
    exp_t q_a[$];
    exp_t q_b[$];
    exp_t cur_a;
    exp_t cur_b;

    always #5 clk = ~clk;

    imm_decode_stage_if #(.N(32), .CNT_W(2))  bus_a ();
    imm_decode_stage_if #(.N(64), .CNT_W(16)) bus_b ();

    imm_decode_stage #(.N(32), .AUTO_FMT(1), .CNT_W(2)) u_dut_a (
        .clk (clk), .rst (rst), .bus (bus_a)
    );
    imm_decode_stage #(.N(64), .AUTO_FMT(0), .CNT_W(16)) u_dut_b (
        .clk (clk), .rst (rst), .bus (bus_b)
    );

    // Directed vectors for the auto-format stage.
    logic [31:0] va_instr [10] = '{32'hFFF00093, 32'hFE112E23, 32'hFFDFF06F, 32'hFE000EE3,
                                   32'h00000463, 32'h12345297, 32'hFFFFD073, 32'h34011073,
                                   32'h002081B3, 32'h80002103};
    logic [63:0] va_imm   [10] = '{64'hFFFFFFFF, 64'hFFFFFFFC, 64'hFFFFFFFC, 64'hFFFFFFFC,
                                   64'h00000008, 64'h12345000, 64'h0000001F, 64'h00000340,
                                   64'h00000000, 64'hFFFFF800};
    logic [2:0]  va_fmt   [10] = '{3'd0, 3'd1, 3'd4, 3'd2, 3'd2, 3'd3, 3'd5, 3'd0, 3'd6, 3'd0};

    // Directed vectors for the 64-bit fmt_sel stage.
    logic [31:0] vb_instr [6] = '{32'h800000B7, 32'hFFF00093, 32'hFE112E23, 32'hFFFFD073,
                                  32'h0000007F, 32'hFFFFFFFF};
    logic [2:0]  vb_sel   [6] = '{3'd3, 3'd0, 3'd1, 3'd5, 3'd7, 3'd6};
    logic [63:0] vb_imm   [6] = '{64'hFFFFFFFF80000000, 64'hFFFFFFFFFFFFFFFF,
                                  64'hFFFFFFFFFFFFFFFC, 64'h000000000000001F,
                                  64'h0, 64'h0};

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: actual=%h required=%h", name, act, req);
        end
    endtask

    task automatic fail_note(input string name);
        total++;
        bad++;
        $display("FAIL %s: actual=timeout required=event", name);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic offer_a(input logic [31:0] ins, input logic [63:0] imm, input logic [2:0] fmt);
        bus_a.in_valid = 1'b1;
        bus_a.instr    = ins;
        cur_a          = '{ins, imm, fmt, (fmt == 3'd7)};
    endtask

    task automatic wait_acc_a();
        int n;
        for (n = 0; n < 50; n++) begin
            @(negedge clk);
            if (bus_a.in_ready) break;
        end
        if (n == 50) fail_note("a_accept_timeout");
        step();
    endtask

    task automatic send_a(input logic [31:0] ins, input logic [63:0] imm, input logic [2:0] fmt);
        offer_a(ins, imm, fmt);
        wait_acc_a();
    endtask

    task automatic drain_a();
        int n;
        bus_a.in_valid = 1'b0;
        for (n = 0; n < 100; n++) begin
            @(negedge clk);
            if (q_a.size() == 0 && !bus_a.out_valid) break;
        end
        if (n == 100) fail_note("a_drain_timeout");
        step();
    endtask

    task automatic chk_reset_a(input string tag);
        chk({tag, "_out_valid"},   64'(bus_a.out_valid),   64'd0);
        chk({tag, "_in_ready"},    64'(bus_a.in_ready),    64'd1);
        chk({tag, "_imm"},         64'(bus_a.imm),         64'd0);
        chk({tag, "_fmt"},         64'(bus_a.fmt),         64'd0);
        chk({tag, "_instr_out"},   64'(bus_a.instr_out),   64'd0);
        chk({tag, "_illegal"},     64'(bus_a.illegal),     64'd0);
        chk({tag, "_illegal_cnt"}, 64'(bus_a.illegal_cnt), 64'd0);
    endtask

    // Monitor A: every cycle the held output must match the oldest expectation.
    always @(negedge clk) begin
        if (mon_en) begin
            chk("a_illegal_cnt", 64'(bus_a.illegal_cnt), 64'(cnt_a));
            if (bus_a.out_valid) begin
                if (q_a.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL a_spurious_output: actual=instr %h required=no output", bus_a.instr_out);
                end else begin
                    chk("a_imm",       64'(bus_a.imm),       q_a[0].imm);
                    chk("a_fmt",       64'(bus_a.fmt),       64'(q_a[0].fmt));
                    chk("a_instr_out", 64'(bus_a.instr_out), 64'(q_a[0].instr));
                    chk("a_illegal",   64'(bus_a.illegal),   64'(q_a[0].ill));
                    if (bus_a.out_ready) begin
                        if (q_a[0].ill && cnt_a < 3) cnt_a++;
                        void'(q_a.pop_front());
                    end
                end
            end
            if (rst) begin
                q_a.delete();
                cnt_a = 0;
            end else if (bus_a.flush) begin
                q_a.delete();
            end else if (bus_a.in_valid && bus_a.in_ready) begin
                q_a.push_back(cur_a);
            end
        end
    end

    always @(negedge clk) begin
        if (mon_en) begin
            chk("b_illegal_cnt", 64'(bus_b.illegal_cnt), 64'(cnt_b));
            if (bus_b.out_valid) begin
                if (q_b.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL b_spurious_output: actual=instr %h required=no output", bus_b.instr_out);
                end else begin
                    chk("b_imm",       bus_b.imm,              q_b[0].imm);
                    chk("b_fmt",       64'(bus_b.fmt),         64'(q_b[0].fmt));
                    chk("b_instr_out", 64'(bus_b.instr_out),   64'(q_b[0].instr));
                    chk("b_illegal",   64'(bus_b.illegal),     64'(q_b[0].ill));
                    if (bus_b.out_ready) begin
                        if (q_b[0].ill) cnt_b++;
                        void'(q_b.pop_front());
                    end
                end
            end
            if (rst) begin
                q_b.delete();
                cnt_b = 0;
            end else if (bus_b.flush) begin
                q_b.delete();
            end else if (bus_b.in_valid && bus_b.in_ready) begin
                q_b.push_back(cur_b);
            end
        end
    end

    // Stage B stimulus: format forced through fmt_sel on a 64-bit datapath.
    initial begin
        int n;
        wait (mon_en == 1'b1);
        bus_b.out_ready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            bus_b.in_valid = 1'b1;
            bus_b.instr    = vb_instr[i];
            bus_b.fmt_sel  = vb_sel[i];
            cur_b          = '{vb_instr[i], vb_imm[i], vb_sel[i], (vb_sel[i] == 3'd7)};
            for (n = 0; n < 50; n++) begin
                @(negedge clk);
                if (bus_b.in_ready) break;
            end
            if (n == 50) fail_note("b_accept_timeout");
            step();
        end
        bus_b.in_valid = 1'b0;
        for (n = 0; n < 100; n++) begin
            @(negedge clk);
            if (q_b.size() == 0 && !bus_b.out_valid) break;
        end
        if (n == 100) fail_note("b_drain_timeout");
        b_done = 1'b1;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: actual=still running required=finished");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int n;
        bus_a.flush = 1'b0; bus_a.in_valid = 1'b0; bus_a.instr = '0;
        bus_a.fmt_sel = '0; bus_a.out_ready = 1'b0;
        bus_b.flush = 1'b0; bus_b.in_valid = 1'b0; bus_b.instr = '0;
        bus_b.fmt_sel = '0; bus_b.out_ready = 1'b0;
        rst = 1'b1;
        repeat (2) step();
        @(negedge clk);
        chk_reset_a("rst_init");
        chk("rst_init_b_out_valid", 64'(bus_b.out_valid), 64'd0);
        step();
        rst    = 1'b0;
        mon_en = 1'b1;

        // Streaming decode, one instruction per cycle.
        bus_a.out_ready = 1'b1;
        for (int i = 0; i < 10; i++) send_a(va_instr[i], va_imm[i], va_fmt[i]);
        drain_a();

        // Backpressure: two accepted, third blocked until release.
        bus_a.out_ready = 1'b0;
        send_a(32'h00500093, 64'h5, 3'd0);
        send_a(32'h00A00113, 64'hA, 3'd0);
        offer_a(32'h123450B7, 64'h12345000, 3'd3);
        @(negedge clk);
        chk("bp_in_ready_drop", 64'(bus_a.in_ready),  64'd0);
        chk("bp_out_valid",     64'(bus_a.out_valid), 64'd1);
        chk("bp_head_instr",    64'(bus_a.instr_out), 64'h00500093);
        repeat (3) begin
            @(negedge clk);
            chk("bp_in_ready_held", 64'(bus_a.in_ready), 64'd0);
        end
        step();
        bus_a.out_ready = 1'b1;
        wait_acc_a();
        drain_a();

        // Flush during a full stall.
        bus_a.out_ready = 1'b0;
        send_a(32'h00100093, 64'h1, 3'd0);
        send_a(32'h00200093, 64'h2, 3'd0);
        offer_a(32'h00300093, 64'h3, 3'd0);
        bus_a.flush = 1'b1;
        step();
        bus_a.flush    = 1'b0;
        bus_a.in_valid = 1'b0;
        @(negedge clk);
        chk("flush_out_valid", 64'(bus_a.out_valid), 64'd0);
        chk("flush_in_ready",  64'(bus_a.in_ready),  64'd1);
        step();
        bus_a.out_ready = 1'b1;
        repeat (4) step();

        // Input handshaken in the flush cycle is dropped.
        bus_a.out_ready = 1'b0;
        send_a(32'h00400093, 64'h4, 3'd0);
        offer_a(32'h00600093, 64'h6, 3'd0);
        bus_a.flush = 1'b1;
        step();
        bus_a.flush    = 1'b0;
        bus_a.in_valid = 1'b0;
        @(negedge clk);
        chk("flush_in_out_valid", 64'(bus_a.out_valid), 64'd0);
        step();
        bus_a.out_ready = 1'b1;
        repeat (3) step();
        send_a(32'h00700093, 64'h7, 3'd0);
        drain_a();

        // Illegal counting saturates at 3 for a 2-bit counter.
        for (int i = 0; i < 5; i++) send_a(32'h0000007F, 64'h0, 3'd7);
        drain_a();
        @(negedge clk);
        chk("ill_cnt_saturated", 64'(bus_a.illegal_cnt), 64'd3);
        step();

        // Reset in the middle of a full stall.
        bus_a.out_ready = 1'b0;
        send_a(32'h00800093, 64'h8, 3'd0);
        send_a(32'h00900093, 64'h9, 3'd0);
        offer_a(32'h00A00093, 64'hA, 3'd0);
        rst = 1'b1;
        step();
        rst            = 1'b0;
        bus_a.in_valid = 1'b0;
        @(negedge clk);
        chk_reset_a("rst_stall");
        step();
        bus_a.out_ready = 1'b1;
        repeat (3) step();

        for (n = 0; n < 200; n++) begin
            if (b_done) break;
            step();
        end
        if (n == 200) fail_note("b_done_timeout");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire
